// File: rtl/damped_comb_filter.sv
// rtl/damped_comb_filter.sv - Freeverb-style lowpass-feedback comb filter, one channel
module damped_comb_filter #(
    parameter int DATA_W    = 24,
    parameter int COEF_W    = 25,
    parameter int DELAY_LEN = 1116,
    parameter int ADDR_W    = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sink_data,
    input  logic              sink_valid,
    output logic              sink_ready,
    output logic [DATA_W-1:0] source_data,
    output logic              source_valid,
    input  logic              source_ready,
    input  logic [COEF_W-1:0] decay_value,
    input  logic [COEF_W-1:0] damping_value
);
    localparam int FRAC = 24;
    localparam int PROD_W = DATA_W + COEF_W + 1;
    localparam logic [COEF_W-1:0] ONE = COEF_W'(1 << FRAC);

    typedef enum logic [2:0] {CLEAR, IDLE, RD, MAC, WR, OUT} state_t;
    state_t state_q, state_d;

    logic [ADDR_W:0]            clr_cnt;
    logic [ADDR_W-1:0]          idx;
    logic signed [DATA_W-1:0]   x_q, f_q, f_new;
    logic [COEF_W-1:0]          d_q, g_q;
    logic                       accept;

    logic signed [DATA_W-1:0]   mem [DELAY_LEN];
    logic signed [DATA_W-1:0]   ram_rdata, ram_wdata, sat_val;
    logic [ADDR_W-1:0]          ram_addr;
    logic                       ram_we, ram_re;

    logic signed [COEF_W:0]     d_s, g_s, one_minus_d;
    logic signed [PROD_W-1:0]   damp_r, damp_f, fb_prod, wr_sum;
    logic signed [PROD_W:0]     damp_sum;

    function automatic logic [COEF_W-1:0] clamp_coef(input logic [COEF_W-1:0] c);
        return (c > ONE) ? ONE : c;
    endfunction

    assign accept = (state_q == IDLE) && sink_valid && sink_ready;

    // Damping lowpass: f' = (r*(1-d) + f*d) >>> 24, a convex mix so it always fits DATA_W
    assign d_s         = $signed({1'b0, d_q});
    assign g_s         = $signed({1'b0, g_q});
    assign one_minus_d = $signed({1'b0, ONE}) - d_s;
    assign damp_r      = PROD_W'(ram_rdata) * PROD_W'(one_minus_d);
    assign damp_f      = PROD_W'(f_q) * PROD_W'(d_s);
    assign damp_sum    = (PROD_W+1)'(damp_r) + (PROD_W+1)'(damp_f);
    assign f_new       = DATA_W'(damp_sum >>> FRAC);

    assign fb_prod = PROD_W'(f_q) * PROD_W'(g_s);
    assign wr_sum  = (fb_prod >>> FRAC) + PROD_W'(x_q);

    always_comb begin
        sat_val = wr_sum[DATA_W-1:0];
        if (!(wr_sum[PROD_W-1:DATA_W-1] == '0 || wr_sum[PROD_W-1:DATA_W-1] == '1)) begin
            sat_val = wr_sum[PROD_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR:   if (clr_cnt == (ADDR_W+1)'(DELAY_LEN)) state_d = IDLE;
            IDLE:    if (accept) state_d = RD;
            RD:      state_d = MAC;
            MAC:     state_d = WR;
            WR:      state_d = OUT;
            OUT:     if (source_ready) state_d = IDLE;
            default: state_d = CLEAR;
        endcase
    end

    // Reset gates the write so a sample caught in flight never reaches the delay line
    always_comb begin
        ram_addr  = (state_q == CLEAR) ? clr_cnt[ADDR_W-1:0] : idx;
        ram_wdata = (state_q == CLEAR) ? '0 : sat_val;
        ram_re    = (state_q == RD);
        ram_we    = !reset && (((state_q == CLEAR) && (clr_cnt < (ADDR_W+1)'(DELAY_LEN)))
                               || (state_q == WR));
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end else if (ram_re) begin
            ram_rdata <= mem[ram_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= CLEAR;
            clr_cnt      <= '0;
            idx          <= '0;
            f_q          <= '0;
            sink_ready   <= 1'b0;
            source_valid <= 1'b0;
            source_data  <= '0;
        end else begin
            state_q      <= state_d;
            sink_ready   <= (state_d == IDLE);
            source_valid <= (state_d == OUT);
            if (state_q == CLEAR) begin
                clr_cnt <= clr_cnt + (ADDR_W+1)'(1);
            end
            if (accept) begin
                x_q <= sink_data;
                d_q <= clamp_coef(damping_value);
                g_q <= clamp_coef(decay_value);
            end
            if (state_q == MAC) begin
                f_q <= f_new;
            end
            if (state_q == WR) begin
                source_data <= ram_rdata;
                idx <= (idx == ADDR_W'(DELAY_LEN - 1)) ? '0 : idx + ADDR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_damped_comb_filter.sv
// tb/tb_damped_comb_filter.sv - scoreboard bench for damped_comb_filter
module tb_damped_comb_filter;
    localparam int L = 13;
    localparam int AW = 4;
    localparam int ONE = 32'h1000000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] sink_data = '0;
    logic        sink_valid = 1'b0;
    logic        sink_ready;
    logic [23:0] source_data;
    logic        source_valid;
    logic        source_ready = 1'b0;
    logic [24:0] decay_value = '0;
    logic [24:0] damping_value = '0;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int got[64];
    int n_got = 0;

    int     m_buf[L];
    longint m_f;
    int     m_idx;

    damped_comb_filter #(.DATA_W(24), .COEF_W(25), .DELAY_LEN(L), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .sink_data(sink_data), .sink_valid(sink_valid), .sink_ready(sink_ready),
        .source_data(source_data), .source_valid(source_valid), .source_ready(source_ready),
        .decay_value(decay_value), .damping_value(damping_value)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    function automatic void model_reset();
        for (int i = 0; i < L; i++) m_buf[i] = 0;
        m_f = 0;
        m_idx = 0;
    endfunction

    function automatic int model_step(input longint x, input longint d, input longint g);
        longint r, fp, s;
        if (d > ONE) d = ONE;
        if (g > ONE) g = ONE;
        r  = m_buf[m_idx];
        fp = (r * (ONE - d) + m_f * d) >>> 24;
        s  = x + ((fp * g) >>> 24);
        if (s > longint'(8388607)) s = 8388607;
        if (s < -longint'(8388608)) s = -8388608;
        m_buf[m_idx] = int'(s);
        m_f = fp;
        m_idx = (m_idx + 1) % L;
        return int'(r);
    endfunction

    // Counts cycles from the current (reset-release) cycle until sink_ready rises
    task automatic wait_clear(output int n, output int sv_seen);
        n = 0;
        sv_seen = 0;
        while (sink_ready !== 1'b1 && n < 4 * L) begin
            if (source_valid !== 1'b0) sv_seen++;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic apply_reset(input int g, input int d);
        int n, sv;
        @(negedge clk);
        decay_value = 25'(g);
        damping_value = 25'(d);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_clear(n, sv);
        checks++;
        if (n != L + 1 || sv != 0)
            $display("FAIL clear_len: got %0d cycles (valid seen %0d), required %0d (0)", n, sv, L + 1);
        if (n != L + 1 || sv != 0) errors++;
        model_reset();
        exp_q.delete();
        n_got = 0;
    endtask

    task automatic send(input int x);
        int t = 0;
        @(negedge clk);
        sink_data = x[23:0];
        sink_valid = 1'b1;
        while (sink_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (sink_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: sink_ready=%b, required 1", sink_ready);
            sink_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back(model_step(longint'(x), longint'(damping_value), longint'(decay_value)));
        #1 sink_valid = 1'b0;
    endtask

    // Pops the scoreboard on the output handshake; hold cycles of backpressure first
    task automatic recv(input int hold);
        int t, exp, act;
        @(negedge clk);
        t = 1;
        checks++;
        if (sink_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_accept: sink_ready=%b, required 0", sink_ready);
        end
        while (source_valid !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t != 4) begin
            errors++;
            $display("FAIL latency: source_valid in cycle %0d, required 4", t);
        end
        if (source_valid !== 1'b1 || exp_q.size() == 0) return;
        exp = exp_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            act = $signed(source_data);
            checks++;
            if (source_valid !== 1'b1 || act != exp || sink_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: valid=%b data=%h ready=%b, required 1 %h 0",
                         i, source_valid, source_data, sink_ready, exp[23:0]);
            end
            @(negedge clk);
        end
        act = $signed(source_data);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL data[%0d]: got %h, required %h", n_got, source_data, exp[23:0]);
        end
        if (n_got < 64) got[n_got] = act;
        n_got++;
        source_ready = 1'b1;
        @(posedge clk);
        #1 source_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (sink_ready !== 1'b1 || source_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_handshake: ready=%b valid=%b, required 1 0", sink_ready, source_valid);
        end
    endtask

    task automatic test_reset();
        int n, sv;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (sink_ready !== 1'b0 || source_valid !== 1'b0 || source_data !== 24'h0) begin
            errors++;
            $display("FAIL reset_state: ready=%b valid=%b data=%h, required 0 0 0",
                     sink_ready, source_valid, source_data);
        end
        reset = 1'b0;
        wait_clear(n, sv);
        checks++;
        if (n != L + 1 || sv != 0) begin
            errors++;
            $display("FAIL reset_clear: %0d cycles (valid %0d), required %0d (0)", n, sv, L + 1);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_clear(n, sv);
        checks++;
        if (n != L + 1 || sv != 0) begin
            errors++;
            $display("FAIL mid_clear_restart: %0d cycles (valid %0d), required %0d (0)", n, sv, L + 1);
        end
    endtask

    task automatic test_plain_delay_backpressure();
        apply_reset(0, 0);
        for (int i = 0; i < 2 * L + 2; i++) begin
            send(i == 0 ? 32'h100000 : 0);
            recv(i == L ? 10 : 0);
        end
        for (int i = 0; i < 2 * L + 2; i++) begin
            checks++;
            if (got[i] != ((i == L) ? 32'h100000 : 0)) begin
                errors++;
                $display("FAIL plain[%0d]: got %h, required %h", i, got[i], (i == L) ? 32'h100000 : 0);
            end
        end
    endtask

    task automatic test_feedback_latch();
        int e;
        apply_reset(32'h0800000, 0);
        for (int i = 0; i < 3 * L + 2; i++) begin
            send(i == 0 ? 32'h400000 : 0);
            if (i == L) decay_value = 25'h1000000;
            recv(0);
            decay_value = 25'h0800000;
        end
        for (int i = 0; i < 3 * L + 2; i++) begin
            e = (i == L) ? 32'h400000 : (i == 2 * L) ? 32'h200000 : (i == 3 * L) ? 32'h100000 : 0;
            checks++;
            if (got[i] != e) begin
                errors++;
                $display("FAIL feedback[%0d]: got %h, required %h", i, got[i], e);
            end
        end
    endtask

    task automatic test_damping();
        int e[4];
        apply_reset(32'h1000000, 32'h0800000);
        for (int i = 0; i < 2 * L + 3; i++) begin
            send(i == 0 ? 32'h400000 : 0);
            recv(0);
        end
        e = '{32'h400000, 32'h200000, 32'h100000, 32'h080000};
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got[(k == 0) ? L : 2 * L + k - 1] != e[k]) begin
                errors++;
                $display("FAIL damping[%0d]: got %h, required %h", k, got[(k == 0) ? L : 2 * L + k - 1], e[k]);
            end
        end
    endtask

    task automatic test_saturation();
        int x;
        for (int s = 0; s < 2; s++) begin
            x = (s == 0) ? 32'h7FFFFF : -32'sh800000;
            apply_reset(32'h1FFFFFF, 0);
            for (int i = 0; i < 2 * L + 3; i++) begin
                send(x);
                recv(0);
            end
            for (int i = 2 * L; i < 2 * L + 3; i++) begin
                checks++;
                if (got[i] != x) begin
                    errors++;
                    $display("FAIL saturation[%0d][%0d]: got %h, required %h", s, i, got[i], x);
                end
            end
        end
    endtask

    task automatic test_reset_in_mac();
        int n, sv;
        apply_reset(32'h1000000, 0);
        send(32'h123456);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (source_valid !== 1'b0 || sink_ready !== 1'b0) begin
            errors++;
            $display("FAIL mac_reset_state: valid=%b ready=%b, required 0 0", source_valid, sink_ready);
        end
        reset = 1'b0;
        wait_clear(n, sv);
        checks++;
        if (n != L + 1 || sv != 0) begin
            errors++;
            $display("FAIL mac_reset_clear: %0d cycles (valid %0d), required %0d (0)", n, sv, L + 1);
        end
        model_reset();
        exp_q.delete();
        n_got = 0;
        send(32'h000321);
        recv(0);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_plain_delay_backpressure();
        test_feedback_latch();
        test_damping();
        test_saturation();
        test_reset_in_mac();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
